// File: rtl/bt_uart_pkg.sv
// Shared definitions for the Bluetooth UART receiver: register map, status
// word layout and receiver FSM state encodings.
package bt_uart_pkg;

    localparam logic [3:0] ADDR_DATA = 4'd0;
    localparam logic [3:0] ADDR_STAT = 4'd2;
    localparam logic [3:0] ADDR_CTRL = 4'd4;

    localparam int STAT_EMPTY     = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVERRUN   = 2;
    localparam int STAT_FRAME_ERR = 3;
    localparam int STAT_COUNT_LSB = 7;
    localparam int STAT_COUNT_MSB = 15;

    localparam int CTRL_CLR_OVERRUN   = 0;
    localparam int CTRL_CLR_FRAME_ERR = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    function automatic logic [15:0] status_word(
        input logic [8:0] count,
        input logic       frame_err,
        input logic       overrun,
        input logic       full,
        input logic       empty
    );
        logic [15:0] w;
        w = 16'h0000;
        w[STAT_COUNT_MSB:STAT_COUNT_LSB] = count;
        w[STAT_FRAME_ERR]                = frame_err;
        w[STAT_OVERRUN]                  = overrun;
        w[STAT_FULL]                     = full;
        w[STAT_EMPTY]                    = empty;
        return w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty/count; a push into a full FIFO
// is accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_ZERO = (AW + 1)'(0);
    localparam logic [AW:0]   CNT_MAX  = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             full_r;
    logic             empty_r;
    logic             do_push_s;
    logic             do_pop_s;
    logic [AW:0]      count_nxt_s;

    // Qualify push/pop against the current occupancy and compute the next count.
    always_comb begin
        do_pop_s    = pop & ~empty_r;
        do_push_s   = push & (~full_r | do_pop_s);
        count_nxt_s = count_r;
        case ({do_push_s, do_pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointer, count and flag state; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= CNT_ZERO;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CNT_MAX);
            empty_r <= (count_nxt_s == CNT_ZERO);
        end
    end

    // Storage array; contents need no reset because empty gates every read.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign full  = full_r;
    assign empty = empty_r;
    assign count = count_r;

endmodule

// File: rtl/bt_uart_rx.sv
// 8N1 UART receiver for the Bluetooth link: synchronised line, start/data/stop
// FSM sampling mid-bit, receive FIFO and a small register interface on the J1 bus.
module bt_uart_rx
    import bt_uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_i,
    input  logic        rx_i,
    input  logic        cs_i,
    input  logic        rd_i,
    input  logic        wr_i,
    input  logic [3:0]  addr_i,
    input  logic [15:0] d_in_i,
    output logic [15:0] d_out_o,
    output logic        irq_o
);

    localparam int DIV_RAW = CLK_FREQ / BAUD;
    localparam int DIV     = (DIV_RAW < 4) ? 4 : DIV_RAW;
    localparam int CW      = $clog2(DIV);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2);
    localparam logic [CW-1:0] CNT_BIT  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic            rx_meta_r;
    logic            rx_sync_r;
    logic            rx_prev_r;
    rx_state_t       state_r;
    logic [CW-1:0]   baud_cnt_r;
    logic [2:0]      bit_idx_r;
    logic [7:0]      shift_r;
    logic            push_r;
    logic [7:0]      push_data_r;
    logic            ferr_set_r;
    logic            frame_err_r;
    logic            overrun_r;
    logic [15:0]     d_out_r;

    logic            fall_s;
    logic            rd_stb_s;
    logic            wr_ctrl_s;
    logic            pop_s;
    logic            ovr_set_s;
    logic [8:0]      count9_s;
    logic [7:0]      fifo_rdata_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic [AW:0]     fifo_count_s;
    logic            unused_s;

    // Bus strobes, edge detect and FIFO side conditions.
    always_comb begin
        fall_s    = rx_prev_r & ~rx_sync_r;
        rd_stb_s  = cs_i & rd_i;
        wr_ctrl_s = cs_i & wr_i & (addr_i == ADDR_CTRL);
        if (rd_stb_s && (addr_i == ADDR_DATA) && !fifo_empty_s) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
        ovr_set_s = push_r & fifo_full_s & ~pop_s;
        count9_s  = 9'(fifo_count_s);
    end

    assign unused_s = ^d_in_i[15:2];

    // Two-flop synchroniser plus one delay stage for falling-edge detection.
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rx_i;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // Receiver FSM; the half-bit start delay puts every later sample mid-bit.
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            state_r     <= IDLE;
            baud_cnt_r  <= CNT_ZERO;
            bit_idx_r   <= 3'd0;
            shift_r     <= 8'h00;
            push_r      <= 1'b0;
            push_data_r <= 8'h00;
            ferr_set_r  <= 1'b0;
        end else begin
            push_r     <= 1'b0;
            ferr_set_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (fall_s) begin
                        state_r    <= START;
                        baud_cnt_r <= CNT_HALF;
                    end
                end
                START: begin
                    if (baud_cnt_r == CNT_ZERO) begin
                        if (!rx_sync_r) begin
                            state_r    <= DATA;
                            baud_cnt_r <= CNT_BIT;
                            bit_idx_r  <= 3'd0;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r - CNT_ONE;
                    end
                end
                DATA: begin
                    if (baud_cnt_r == CNT_ZERO) begin
                        shift_r    <= {rx_sync_r, shift_r[7:1]};
                        baud_cnt_r <= CNT_BIT;
                        if (bit_idx_r == 3'd7) begin
                            state_r <= STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r - CNT_ONE;
                    end
                end
                STOP: begin
                    if (baud_cnt_r == CNT_ZERO) begin
                        if (rx_sync_r) begin
                            push_r      <= 1'b1;
                            push_data_r <= shift_r;
                        end else begin
                            ferr_set_r <= 1'b1;
                        end
                        state_r <= IDLE;
                    end else begin
                        baud_cnt_r <= baud_cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Sticky error flags: a set in the same cycle as a clear wins.
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            frame_err_r <= ferr_set_r |
                           (frame_err_r & ~(wr_ctrl_s & d_in_i[CTRL_CLR_FRAME_ERR]));
            overrun_r   <= ovr_set_s |
                           (overrun_r & ~(wr_ctrl_s & d_in_i[CTRL_CLR_OVERRUN]));
        end
    end

    // Registered read data, loaded on the same edge that pops the FIFO.
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            d_out_r <= 16'h0000;
        end else if (rd_stb_s) begin
            case (addr_i)
                ADDR_DATA: d_out_r <= fifo_empty_s ? 16'h0000 : {8'h00, fifo_rdata_s};
                ADDR_STAT: d_out_r <= status_word(count9_s, frame_err_r, overrun_r,
                                                  fifo_full_s, fifo_empty_s);
                default:   d_out_r <= 16'h0000;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (sys_clk_i),
        .rst   (sys_rst_i),
        .push  (push_r),
        .pop   (pop_s),
        .wdata (push_data_r),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    assign d_out_o = d_out_r;
    assign irq_o   = ~fifo_empty_s;

endmodule

// File: tb/tb_bt_uart_rx.sv
// Scoreboard bench for bt_uart_rx at 16 clocks per bit with a 4-entry FIFO.
module tb_bt_uart_rx;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        rx      = 1'b1;
    logic        cs      = 1'b0;
    logic        rd      = 1'b0;
    logic        wr      = 1'b0;
    logic [3:0]  addr    = 4'd0;
    logic [15:0] d_in    = 16'h0000;
    logic [15:0] d_out;
    logic        irq;

    int          total   = 0;
    int          bad     = 0;
    int          rd_num  = 0;
    logic        rd_pend = 1'b0;
    logic [19:0] exp_q [$];

    always #5 sys_clk = ~sys_clk;

    bt_uart_rx #(
        .CLK_FREQ   (16),
        .BAUD       (1),
        .FIFO_DEPTH (4)
    ) dut (
        .sys_clk_i (sys_clk),
        .sys_rst_i (sys_rst),
        .rx_i      (rx),
        .cs_i      (cs),
        .rd_i      (rd),
        .wr_i      (wr),
        .addr_i    (addr),
        .d_in_i    (d_in),
        .d_out_o   (d_out),
        .irq_o     (irq)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, act, exp);
        end
    endtask

    // Note which edges saw a read strobe so the monitor knows d_out is fresh.
    initial forever begin
        @(posedge sys_clk);
        rd_pend = cs & rd;
    end

    initial forever begin
        logic [19:0] ent;
        @(negedge sys_clk);
        if (rd_pend) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_read: got=%h expected=none", d_out);
            end else begin
                ent = exp_q.pop_front();
                check($sformatf("read%0d_addr%0d", rd_num, ent[19:16]), d_out, ent[15:0]);
                rd_num++;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "timeout");
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (16) @(negedge sys_clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (16) @(negedge sys_clk);
        end
        rx = stop_bit;
        repeat (16) @(negedge sys_clk);
        rx = 1'b1;
        repeat (4) @(negedge sys_clk);
    endtask

    task automatic bus_read(input logic [3:0] a, input logic [15:0] exp);
        @(negedge sys_clk);
        cs = 1'b1; rd = 1'b1; addr = a;
        exp_q.push_back({a, exp});
        @(negedge sys_clk);
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [15:0] v);
        @(negedge sys_clk);
        cs = 1'b1; wr = 1'b1; addr = a; d_in = v;
        @(negedge sys_clk);
        cs = 1'b0; wr = 1'b0; d_in = 16'h0000;
    endtask

    initial begin
        logic [7:0] pb;
        // Reset state
        repeat (3) @(negedge sys_clk);
        check("reset_dout", d_out, 16'h0000);
        check("reset_irq", {15'h0000, irq}, 16'h0000);
        sys_rst = 1'b0;
        repeat (4) @(negedge sys_clk);
        bus_read(4'd2, 16'h0001);

        // Single good byte
        send_byte(8'hA5, 1'b1);
        bus_read(4'd2, 16'h0080);
        check("irq_after_push", {15'h0000, irq}, 16'h0001);
        bus_read(4'd0, 16'h00A5);
        check("irq_after_pop", {15'h0000, irq}, 16'h0000);
        bus_read(4'd2, 16'h0001);

        // Framing error, unmapped address, clear
        send_byte(8'h3C, 1'b0);
        bus_read(4'd2, 16'h0009);
        bus_write(4'd6, 16'hFFFF);
        bus_read(4'd6, 16'h0000);
        bus_read(4'd2, 16'h0009);
        bus_write(4'd4, 16'h0002);
        bus_read(4'd2, 16'h0001);

        // Overrun on a full FIFO
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
        bus_read(4'd2, 16'h0206);
        for (int i = 1; i <= 4; i++) bus_read(4'd0, 16'(i));
        bus_read(4'd2, 16'h0005);
        // Simultaneous read and write: read of ctrl returns 0, write clears overrun
        @(negedge sys_clk);
        cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = 4'd4; d_in = 16'h0001;
        exp_q.push_back({4'd4, 16'h0000});
        @(negedge sys_clk);
        cs = 1'b0; rd = 1'b0; wr = 1'b0; d_in = 16'h0000;
        bus_read(4'd2, 16'h0001);

        // Pop on the exact cycle of the 5th push lets it in
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1);
        fork
            send_byte(8'h05, 1'b1);
            begin
                repeat (156) @(negedge sys_clk);
                cs = 1'b1; rd = 1'b1; addr = 4'd0;
                exp_q.push_back({4'd0, 16'h0001});
                @(negedge sys_clk);
                cs = 1'b0; rd = 1'b0;
            end
        join
        bus_read(4'd2, 16'h0202);
        for (int i = 2; i <= 5; i++) bus_read(4'd0, 16'(i));
        bus_read(4'd2, 16'h0001);

        // Short glitch is rejected, receiver still works afterwards
        rx = 1'b0;
        repeat (4) @(negedge sys_clk);
        rx = 1'b1;
        repeat (40) @(negedge sys_clk);
        bus_read(4'd2, 16'h0001);
        send_byte(8'h77, 1'b1);
        bus_read(4'd0, 16'h0077);

        // Reset mid-frame flushes FIFO and partial byte
        send_byte(8'h11, 1'b1);
        check("irq_before_reset", {15'h0000, irq}, 16'h0001);
        pb = 8'h33;
        rx = 1'b0;
        repeat (16) @(negedge sys_clk);
        for (int i = 0; i < 3; i++) begin
            rx = pb[i];
            repeat (16) @(negedge sys_clk);
        end
        rx = pb[3];
        repeat (8) @(negedge sys_clk);
        sys_rst = 1'b1;
        rx = 1'b1;
        repeat (4) @(negedge sys_clk);
        check("midreset_dout", d_out, 16'h0000);
        check("midreset_irq", {15'h0000, irq}, 16'h0000);
        sys_rst = 1'b0;
        repeat (4) @(negedge sys_clk);
        send_byte(8'h5A, 1'b1);
        bus_read(4'd2, 16'h0080);
        bus_read(4'd0, 16'h005A);
        bus_read(4'd2, 16'h0001);

        // Empty read, then wrap with interleaved reads and a held-rd burst
        bus_read(4'd0, 16'h0000);
        bus_read(4'd2, 16'h0001);
        send_byte(8'h10, 1'b1);
        send_byte(8'h20, 1'b1);
        send_byte(8'h30, 1'b1);
        bus_read(4'd0, 16'h0010);
        send_byte(8'h40, 1'b1);
        send_byte(8'h50, 1'b1);
        bus_read(4'd0, 16'h0020);
        bus_read(4'd0, 16'h0030);
        send_byte(8'h60, 1'b1);
        @(negedge sys_clk);
        cs = 1'b1; rd = 1'b1; addr = 4'd0;
        exp_q.push_back({4'd0, 16'h0040});
        exp_q.push_back({4'd0, 16'h0050});
        exp_q.push_back({4'd0, 16'h0060});
        repeat (3) @(negedge sys_clk);
        cs = 1'b0; rd = 1'b0;
        bus_read(4'd2, 16'h0001);
        check("final_irq", {15'h0000, irq}, 16'h0000);

        repeat (3) @(negedge sys_clk);
        check("scoreboard_drained", 16'(exp_q.size()), 16'h0000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
